// File: rtl/issue_queue.sv
// Compacting in-order-priority issue queue with tag wakeup; index 0 always holds the oldest entry.
// Define ISSUE_QUEUE_MEM_ORDER_EN to force loads/stores to issue in program order.
module issue_queue #(
  parameter int DEPTH      = 8,
  parameter int TAG_W      = 6,
  parameter int PAYLOAD_W  = 80,
  parameter int WAKE_PORTS = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        dispatch_valid,
  output logic                        dispatch_ready,
  input  logic [TAG_W-1:0]            dispatch_rs,
  input  logic [TAG_W-1:0]            dispatch_rt,
  input  logic                        dispatch_uses_rs,
  input  logic                        dispatch_uses_rt,
  input  logic                        dispatch_rs_rdy,
  input  logic                        dispatch_rt_rdy,
  input  logic                        dispatch_is_mem,
  input  logic [PAYLOAD_W-1:0]        dispatch_payload,
  input  logic [WAKE_PORTS-1:0]       wake_valid,
  input  logic [WAKE_PORTS*TAG_W-1:0] wake_tag,
  output logic                        issue_valid,
  input  logic                        issue_ready,
  output logic [PAYLOAD_W-1:0]        issue_payload,
  output logic                        issue_is_mem,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        empty,
  output logic                        full
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]     valid_q, rs_rdy_q, rt_rdy_q, mem_q;
  logic [TAG_W-1:0]     rs_tag_q [DEPTH];
  logic [TAG_W-1:0]     rt_tag_q [DEPTH];
  logic [PAYLOAD_W-1:0] payload_q [DEPTH];
  logic [CNT_W-1:0]     count_q;

  logic [DEPTH-1:0]     nxt_valid, nxt_rs_rdy, nxt_rt_rdy, nxt_mem;
  logic [TAG_W-1:0]     nxt_rs_tag [DEPTH];
  logic [TAG_W-1:0]     nxt_rt_tag [DEPTH];
  logic [PAYLOAD_W-1:0] nxt_payload [DEPTH];
  logic [CNT_W-1:0]     nxt_count;

  logic [DEPTH-1:0]     eligible;
  logic [IDX_W-1:0]     sel_idx;
  logic                 do_issue, do_disp;
  logic [CNT_W-1:0]     wr_pos;
  logic                 disp_rs_ok, disp_rt_ok;

  function automatic logic wake_hit(input logic [TAG_W-1:0] tag);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < WAKE_PORTS; p++)
      if (wake_valid[p] && (wake_tag[p*TAG_W +: TAG_W] == tag)) hit = 1'b1;
    return hit;
  endfunction

  assign count          = count_q;
  assign empty          = (count_q == '0);
  assign full           = (count_q == CNT_W'(DEPTH));
  assign dispatch_ready = !full;

  // Eligibility and oldest-first selection use registered state only.
  always_comb begin
    logic mem_seen;
    mem_seen    = 1'b0;
    eligible    = '0;
    issue_valid = 1'b0;
    sel_idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef ISSUE_QUEUE_MEM_ORDER_EN
      eligible[i] = valid_q[i] && rs_rdy_q[i] && rt_rdy_q[i] && !(mem_q[i] && mem_seen);
`else
      eligible[i] = valid_q[i] && rs_rdy_q[i] && rt_rdy_q[i];
`endif
      mem_seen = mem_seen | (valid_q[i] & mem_q[i]);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        issue_valid = 1'b1;
        sel_idx     = IDX_W'(i);
      end
    end
  end

  assign issue_payload = issue_valid ? payload_q[sel_idx] : '0;
  assign issue_is_mem  = issue_valid & mem_q[sel_idx];

  assign do_issue   = issue_valid && issue_ready;
  assign do_disp    = dispatch_valid && dispatch_ready;
  assign wr_pos     = count_q - (do_issue ? CNT_W'(1) : CNT_W'(0));
  assign disp_rs_ok = !dispatch_uses_rs || (dispatch_rs == '0) || dispatch_rs_rdy || wake_hit(dispatch_rs);
  assign disp_rt_ok = !dispatch_uses_rt || (dispatch_rt == '0) || dispatch_rt_rdy || wake_hit(dispatch_rt);

  // Next state: compact out the issued entry, apply wakeups, then append the dispatch at the new tail.
  always_comb begin
    nxt_valid  = valid_q;
    nxt_rs_rdy = rs_rdy_q;
    nxt_rt_rdy = rt_rdy_q;
    nxt_mem    = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      nxt_rs_tag[i]  = rs_tag_q[i];
      nxt_rt_tag[i]  = rt_tag_q[i];
      nxt_payload[i] = payload_q[i];
    end
    if (do_issue) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (IDX_W'(i) >= sel_idx) begin
          nxt_valid[i]   = valid_q[i+1];
          nxt_rs_rdy[i]  = rs_rdy_q[i+1];
          nxt_rt_rdy[i]  = rt_rdy_q[i+1];
          nxt_mem[i]     = mem_q[i+1];
          nxt_rs_tag[i]  = rs_tag_q[i+1];
          nxt_rt_tag[i]  = rt_tag_q[i+1];
          nxt_payload[i] = payload_q[i+1];
        end
      end
      nxt_valid[DEPTH-1] = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (wake_hit(nxt_rs_tag[i])) nxt_rs_rdy[i] = 1'b1;
      if (wake_hit(nxt_rt_tag[i])) nxt_rt_rdy[i] = 1'b1;
    end
    if (do_disp) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == wr_pos) begin
          nxt_valid[i]   = 1'b1;
          nxt_rs_rdy[i]  = disp_rs_ok;
          nxt_rt_rdy[i]  = disp_rt_ok;
          nxt_mem[i]     = dispatch_is_mem;
          nxt_rs_tag[i]  = dispatch_rs;
          nxt_rt_tag[i]  = dispatch_rt;
          nxt_payload[i] = dispatch_payload;
        end
      end
    end
    nxt_count = count_q + (do_disp ? CNT_W'(1) : CNT_W'(0)) - (do_issue ? CNT_W'(1) : CNT_W'(0));
  end

  // Reset outranks flush; both empty the queue on the next edge.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q  <= '0;
      rs_rdy_q <= '0;
      rt_rdy_q <= '0;
      mem_q    <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= nxt_valid;
      rs_rdy_q <= nxt_rs_rdy;
      rt_rdy_q <= nxt_rt_rdy;
      mem_q    <= nxt_mem;
      count_q  <= nxt_count;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      rs_tag_q[i]  <= nxt_rs_tag[i];
      rt_tag_q[i]  <= nxt_rt_tag[i];
      payload_q[i] <= nxt_payload[i];
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Directed self-checking bench for issue_queue (default parameters).
// Mem-ordering expectations follow ISSUE_QUEUE_MEM_ORDER_EN when it is defined.
module tb_issue_queue;

  logic        clk = 1'b0;
  logic        rst, flush, dispatch_valid, dispatch_ready;
  logic [5:0]  dispatch_rs, dispatch_rt;
  logic        dispatch_uses_rs, dispatch_uses_rt, dispatch_rs_rdy, dispatch_rt_rdy, dispatch_is_mem;
  logic [79:0] dispatch_payload;
  logic [1:0]  wake_valid;
  logic [11:0] wake_tag;
  logic        issue_valid, issue_ready, issue_is_mem;
  logic [79:0] issue_payload;
  logic [3:0]  count;
  logic        empty, full;

  int tests_run    = 0;
  int tests_failed = 0;

  issue_queue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_rs(dispatch_rs), .dispatch_rt(dispatch_rt),
    .dispatch_uses_rs(dispatch_uses_rs), .dispatch_uses_rt(dispatch_uses_rt),
    .dispatch_rs_rdy(dispatch_rs_rdy), .dispatch_rt_rdy(dispatch_rt_rdy),
    .dispatch_is_mem(dispatch_is_mem), .dispatch_payload(dispatch_payload),
    .wake_valid(wake_valid), .wake_tag(wake_tag),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_payload(issue_payload), .issue_is_mem(issue_is_mem),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; dispatch_valid = 0; dispatch_rs = 0; dispatch_rt = 0;
    dispatch_uses_rs = 0; dispatch_uses_rt = 0; dispatch_rs_rdy = 0; dispatch_rt_rdy = 0;
    dispatch_is_mem = 0; dispatch_payload = 0; wake_valid = 0; wake_tag = 0; issue_ready = 0;
  endtask

  task automatic set_dispatch(input logic [79:0] p, input logic urs, input logic [5:0] rs,
                              input logic rrdy, input logic mem);
    dispatch_valid = 1; dispatch_payload = p; dispatch_uses_rs = urs; dispatch_rs = rs;
    dispatch_rs_rdy = rrdy; dispatch_uses_rt = 0; dispatch_rt = 0; dispatch_rt_rdy = 0;
    dispatch_is_mem = mem;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    set_dispatch(80'h77, 0, 0, 0, 1);
    issue_ready = 1;
    tick();
    tick();
    rst = 0;
    idle_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (count !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    tests_run++; if (dispatch_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_dispatch_ready: got %b expected 1", dispatch_ready); end
    tests_run++; if (issue_valid !== 1'b0 || issue_is_mem !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_issue: valid %b mem %b expected 0 0", issue_valid, issue_is_mem); end
    tests_run++; if (issue_payload !== 80'h0) begin tests_failed++; $display("[TB] FAIL reset_payload: got %0h expected 0", issue_payload); end
    tests_run++; if (empty !== 1'b1 || full !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_flags: empty %b full %b expected 1 0", empty, full); end
    issue_ready = 1;
    tick();
    tests_run++; if (issue_valid !== 1'b0 || count !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_stale_dispatch: valid %b count %0d expected 0 0", issue_valid, count); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      set_dispatch(80'd100 + 80'(k), 0, 0, 0, 0);
      tick();
      tests_run++; if (count !== 4'(k + 1)) begin tests_failed++; $display("[TB] FAIL fill_count: got %0d expected %0d", count, k + 1); end
    end
    idle_inputs();
    tests_run++; if (full !== 1'b1 || dispatch_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL fill_full: full %b ready %b expected 1 0", full, dispatch_ready); end
    issue_ready = 1;
    for (int k = 0; k < 8; k++) begin
      tests_run++; if (issue_valid !== 1'b1 || issue_payload !== 80'd100 + 80'(k)) begin tests_failed++; $display("[TB] FAIL drain_order: valid %b payload %0d expected 1 %0d", issue_valid, issue_payload, 100 + k); end
      tick();
    end
    tests_run++; if (empty !== 1'b1 || issue_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL drain_empty: empty %b valid %b expected 1 0", empty, issue_valid); end
  endtask

  task automatic test_wakeup();
    do_reset();
    set_dispatch(80'hA, 1, 6'd9, 0, 0);
    tick();
    set_dispatch(80'hB, 0, 0, 0, 0);
    tick();
    idle_inputs();
    tests_run++; if (issue_valid !== 1'b1 || issue_payload !== 80'hB) begin tests_failed++; $display("[TB] FAIL wake_young_first: valid %b payload %0h expected 1 b", issue_valid, issue_payload); end
    issue_ready = 1;
    tick();
    tests_run++; if (issue_valid !== 1'b0 || count !== 4'd1) begin tests_failed++; $display("[TB] FAIL wake_blocked: valid %b count %0d expected 0 1", issue_valid, count); end
    wake_valid = 2'b10; wake_tag = {6'd9, 6'd0};
    tests_run++; if (issue_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL wake_same_cycle: got %b expected 0", issue_valid); end
    tick();
    wake_valid = 0; wake_tag = 0;
    tests_run++; if (issue_valid !== 1'b1 || issue_payload !== 80'hA) begin tests_failed++; $display("[TB] FAIL wake_next_cycle: valid %b payload %0h expected 1 a", issue_valid, issue_payload); end
    tick();
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL wake_drained: empty %b expected 1", empty); end
  endtask

  task automatic test_full_simul();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      set_dispatch(80'd200 + 80'(k), 0, 0, 0, 0);
      tick();
    end
    set_dispatch(80'hDEAD, 0, 0, 0, 0);
    issue_ready = 1;
    tests_run++; if (issue_payload !== 80'd200) begin tests_failed++; $display("[TB] FAIL full_simul_head: got %0d expected 200", issue_payload); end
    tick();
    idle_inputs();
    tests_run++; if (count !== 4'd7 || dispatch_ready !== 1'b1 || full !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_simul_count: count %0d ready %b full %b expected 7 1 0", count, dispatch_ready, full); end
    issue_ready = 1;
    for (int k = 1; k < 8; k++) begin
      tests_run++; if (issue_valid !== 1'b1 || issue_payload !== 80'd200 + 80'(k)) begin tests_failed++; $display("[TB] FAIL full_simul_drain: valid %b payload %0h expected 1 %0h", issue_valid, issue_payload, 200 + k); end
      tick();
    end
    tests_run++; if (issue_valid !== 1'b0 || empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_simul_ignored: valid %b empty %b expected 0 1", issue_valid, empty); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_dispatch(80'h31, 0, 0, 0, 0);
    tick();
    set_dispatch(80'h32, 0, 0, 0, 0);
    tick();
    set_dispatch(80'h33, 0, 0, 0, 0);
    issue_ready = 1;
    tests_run++; if (issue_payload !== 80'h31) begin tests_failed++; $display("[TB] FAIL b2b_head: got %0h expected 31", issue_payload); end
    tick();
    idle_inputs();
    issue_ready = 1;
    tests_run++; if (count !== 4'd2 || issue_payload !== 80'h32) begin tests_failed++; $display("[TB] FAIL b2b_count: count %0d payload %0h expected 2 32", count, issue_payload); end
    tick();
    tests_run++; if (issue_payload !== 80'h33 || count !== 4'd1) begin tests_failed++; $display("[TB] FAIL b2b_tail: payload %0h count %0d expected 33 1", issue_payload, count); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_dispatch(80'h50 + 80'(k), 0, 0, 0, 0);
      tick();
    end
    tests_run++; if (count !== 4'd5) begin tests_failed++; $display("[TB] FAIL flush_pre_count: got %0d expected 5", count); end
    set_dispatch(80'hBAD, 0, 0, 0, 0);
    flush = 1;
    tests_run++; if (issue_valid !== 1'b1 || issue_payload !== 80'h50) begin tests_failed++; $display("[TB] FAIL flush_cycle_issue: valid %b payload %0h expected 1 50", issue_valid, issue_payload); end
    tick();
    idle_inputs();
    tests_run++; if (count !== 4'd0 || empty !== 1'b1 || issue_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_after: count %0d empty %b valid %b expected 0 1 0", count, empty, issue_valid); end
    issue_ready = 1;
    tick();
    tests_run++; if (issue_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_dropped_dispatch: got %b expected 0", issue_valid); end
  endtask

  task automatic test_mem_order();
    do_reset();
    set_dispatch(80'h111, 1, 6'd12, 0, 1);
    tick();
    set_dispatch(80'h222, 0, 0, 0, 1);
    tick();
    idle_inputs();
`ifdef ISSUE_QUEUE_MEM_ORDER_EN
    tests_run++; if (issue_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL mem_order_hold: got %b expected 0", issue_valid); end
`else
    tests_run++; if (issue_valid !== 1'b1 || issue_payload !== 80'h222 || issue_is_mem !== 1'b1) begin tests_failed++; $display("[TB] FAIL mem_no_order: valid %b payload %0h mem %b expected 1 222 1", issue_valid, issue_payload, issue_is_mem); end
`endif
    wake_valid = 2'b01; wake_tag = {6'd0, 6'd12};
    tick();
    idle_inputs();
    tests_run++; if (issue_valid !== 1'b1 || issue_payload !== 80'h111 || issue_is_mem !== 1'b1) begin tests_failed++; $display("[TB] FAIL mem_m1: valid %b payload %0h mem %b expected 1 111 1", issue_valid, issue_payload, issue_is_mem); end
    issue_ready = 1;
    tick();
    tests_run++; if (issue_valid !== 1'b1 || issue_payload !== 80'h222) begin tests_failed++; $display("[TB] FAIL mem_m2: valid %b payload %0h expected 1 222", issue_valid, issue_payload); end
    tick();
  endtask

  task automatic test_dispatch_wake();
    do_reset();
    set_dispatch(80'h5, 1, 6'd5, 0, 0);
    wake_valid = 2'b01; wake_tag = {6'd0, 6'd5};
    tick();
    idle_inputs();
    tests_run++; if (issue_valid !== 1'b1 || issue_payload !== 80'h5) begin tests_failed++; $display("[TB] FAIL disp_wake: valid %b payload %0h expected 1 5", issue_valid, issue_payload); end
    issue_ready = 1;
    tick();
    set_dispatch(80'h60, 1, 6'd0, 0, 0);
    dispatch_uses_rt = 1; dispatch_rt = 6'd7; dispatch_rt_rdy = 1;
    issue_ready = 0;
    tick();
    idle_inputs();
    tests_run++; if (issue_valid !== 1'b1 || issue_payload !== 80'h60) begin tests_failed++; $display("[TB] FAIL disp_tag0: valid %b payload %0h expected 1 60", issue_valid, issue_payload); end
    issue_ready = 1;
    tick();
    set_dispatch(80'h70, 1, 6'd3, 0, 0);
    issue_ready = 0;
    tick();
    idle_inputs();
    tests_run++; if (issue_valid !== 1'b0 || count !== 4'd1) begin tests_failed++; $display("[TB] FAIL disp_not_ready: valid %b count %0d expected 0 1", issue_valid, count); end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_fill_drain();
    test_wakeup();
    test_full_simul();
    test_back_to_back();
    test_flush();
    test_mem_order();
    test_dispatch_wake();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of entries (power of two, >=2).
REQ-002 SHALL have parameter TAG_W, default 6, physical register tag width (matches the MipsReg encoding).
REQ-003 SHALL have parameter PAYLOAD_W, default 80, opaque entry payload width (alu_ctl, rw tag, immediate, branch target, mem_action).
REQ-004 SHALL have parameter WAKE_PORTS, default 2, number of wakeup broadcast ports.
REQ-005 SHALL have ports:
- clk  in  1  clock; single clock domain, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  discard all entries.
- dispatch_valid  in  1  new entry offered.
- dispatch_ready  out  1  space available.
- dispatch_rs / dispatch_rt  in  TAG_W each  source tags.
- dispatch_uses_rs / dispatch_uses_rt  in  1 each  source used.
- dispatch_rs_rdy / dispatch_rt_rdy  in  1 each  source value already available.
- dispatch_is_mem  in  1  load/store.
- dispatch_payload  in  PAYLOAD_W  carried unchanged.
- wake_valid  in  WAKE_PORTS  per-port broadcast valid.
- wake_tag  in  WAKE_PORTS*TAG_W  per-port tag; port i at bits [i*TAG_W +: TAG_W].
- issue_valid  out  1  entry offered downstream.
- issue_ready  in  1  downstream accepts.
- issue_payload  out  PAYLOAD_W  payload of the offered entry.
- issue_is_mem  out  1  offered entry is load/store.
- count  out  $clog2(DEPTH)+1  occupied entries.
- empty / full  out  1 each  count==0 / count==DEPTH.

Function
REQ-006 SHALL store entries in a compacting array; index 0 is always the oldest, and valid entries are contiguous from index 0.
REQ-007 SHALL drive dispatch_ready = !full, computed from registered count only (no same-cycle issue credit).
REQ-008 SHALL write a dispatch on dispatch_valid && dispatch_ready at the post-compaction tail position.
REQ-009 SHALL store a source as ready if it is unused, its tag is 0, its *_rdy input is set, or it matches any valid wake port in the dispatch cycle.
REQ-010 SHALL set a stored entry's rs/rt ready bit when any valid wake port carries a matching tag; the bit never clears until the entry leaves.
REQ-011 SHALL treat an entry as eligible when it is valid and both source-ready bits are set, using registered state only; wakeup-to-issue latency is 1 cycle.
REQ-012 SHALL select the lowest-index eligible entry; issue_valid, issue_payload and issue_is_mem SHALL be combinational from registered state.
REQ-013 SHALL remove the selected entry on issue_valid && issue_ready and shift all higher entries down by one in the same edge.
REQ-014 SHALL hold issue_payload stable while issue_valid && !issue_ready, unless an older entry becomes eligible.
REQ-015 SHALL leave count unchanged on simultaneous dispatch and issue; the new entry lands at index count-1.
REQ-016 SHALL give flush priority over dispatch, issue and wakeup: all entries invalid and count=0 on the next cycle; issue_valid remains combinational during the flush cycle.
REQ-017 SHALL ignore dispatch_valid while full, with no state change.

Reset
REQ-018 SHALL, with rst high at a clock edge, clear all valid and ready bits and set count=0; rst has priority over flush.
REQ-019 SHALL drive after reset: dispatch_ready=1, issue_valid=0, issue_is_mem=0, issue_payload=0, empty=1, full=0.
REQ-020 SHALL discard any in-progress handshake when reset is asserted mid-operation.

Configuration
REQ-021 SHALL, when ISSUE_QUEUE_MEM_ORDER_EN is defined, make a mem entry eligible only if no valid older mem entry exists (loads/stores issue in program order).
REQ-022 SHALL, without ISSUE_QUEUE_MEM_ORDER_EN, apply no ordering: mem entries follow REQ-011 like all others.

Verification
REQ-023 Dispatch 8 entries, all sources ready, issue_ready=1 -> issued in dispatch order, one per cycle; full=1 after the 8th dispatch.
REQ-024 Entry A (rs=9, not ready) at index 0, entry B ready at index 1 -> B issues first; wake_tag=9 in cycle N -> A issue_valid in cycle N+1.
REQ-025 Full queue, dispatch_valid=1 and issue handshake in the same cycle -> dispatch ignored, count goes 8->7, dispatch_ready=1 next cycle.
REQ-026 count=5, flush together with dispatch_valid=1 -> count=0, empty=1 next cycle; the dispatched entry is never issued.
REQ-027 Mem entries M1 (not ready) then M2 (ready) -> with ISSUE_QUEUE_MEM_ORDER_EN, M2 held until M1 issues; without it, M2 issues immediately.
REQ-028 Dispatch with rs=5 while wake_tag=5 is valid in the same cycle -> entry eligible next cycle; rs=0 with dispatch_rs_rdy=0 -> eligible next cycle.
